edge_detect_multi: RTL and testbench

//  Parametrised, multi-channel edge detector for asynchronous inputs such as buttons, triggers and external strobes.

---
 rtl/edge_detect_multi.sv | 152 +++++++++++++++
 tb/tb_edge_detect_multi.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector for asynchronous pins.
// Each channel: synchroniser chain -> debounce filter FSM -> registered
// edge pulse gated by a per-channel mode, plus a sticky event flag.

module edge_detect_multi #(
    parameter int NUM_CH        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     signal_i,
    input  logic [2*NUM_CH-1:0]   mode_i,
    input  logic [NUM_CH-1:0]     clr_i,
    output logic [NUM_CH-1:0]     level_o,
    output logic [NUM_CH-1:0]     edge_o,
    output logic [NUM_CH-1:0]     sticky_o,
    output logic                  any_o
);

    localparam int            CW      = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } state_e;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_e                 state_q, state_d;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   edge_q, edge_d;
        logic                   sticky_q, sticky_d;
        logic                   accept;

        // Metastability chain; only the last stage feeds the filter.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i[n]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        // Debounce FSM: a new level is accepted only after FILTER_CYCLES
        // consecutive opposing samples; any interruption returns to stable.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            accept  = 1'b0;
            case (state_q)
                STABLE_LO: begin
                    cnt_d = '0;
                    if (s) begin
                        if (FILTER_CYCLES == 1) begin
                            state_d = STABLE_HI;
                            level_d = 1'b1;
                            accept  = 1'b1;
                        end else begin
                            state_d = QUAL_HI;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                QUAL_HI: begin
                    if (!s) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else if ((cnt_q + CNT_ONE) == CNT_MAX) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        accept  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    cnt_d = '0;
                    if (!s) begin
                        if (FILTER_CYCLES == 1) begin
                            state_d = STABLE_LO;
                            level_d = 1'b0;
                            accept  = 1'b1;
                        end else begin
                            state_d = QUAL_LO;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                QUAL_LO: begin
                    if (s) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else if ((cnt_q + CNT_ONE) == CNT_MAX) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        accept  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end
            endcase
        end

        // Pulse only for directions enabled by the mode sampled at the
        // accepting edge; the sticky set term also covers the pulse cycle
        // so a clear arriving alongside the pulse never drops the event.
        always_comb begin
            edge_d   = accept & (level_d ? mode_i[2*n] : mode_i[2*n+1]);
            sticky_d = edge_d | edge_q | (sticky_q & ~clr_i[n]);
        end

        // Filter state and channel output registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= STABLE_LO;
                cnt_q    <= '0;
                level_q  <= 1'b0;
                edge_q   <= 1'b0;
                sticky_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                level_q  <= level_d;
                edge_q   <= edge_d;
                sticky_q <= sticky_d;
            end
        end

        assign level_o[n]  = level_q;
        assign edge_o[n]   = edge_q;
        assign sticky_o[n] = sticky_q;
    end

    assign any_o = |sticky_o;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Testbench for edge_detect_multi: directed table, hand-written corner
// sequences and randomized traffic against a behavioural reference model.

module tb_edge_detect_multi;

    localparam int NUM_CH = 4;
    localparam int SYNC   = 2;
    localparam int FILT   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] signal_i, clr_i, level_o, edge_o, sticky_o;
    logic [7:0] mode_i;
    logic       any_o;

    logic [3:0] sig2, lvl2, edg2, stk2;
    logic       any2;

    always #5 clk = ~clk;

    edge_detect_multi #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT)) dut (
        .clk(clk), .rst_n(rst_n), .signal_i(signal_i), .mode_i(mode_i), .clr_i(clr_i),
        .level_o(level_o), .edge_o(edge_o), .sticky_o(sticky_o), .any_o(any_o)
    );

    edge_detect_multi #(.NUM_CH(4), .SYNC_STAGES(3), .FILTER_CYCLES(1)) dutFast (
        .clk(clk), .rst_n(rst_n), .signal_i(sig2), .mode_i(8'h55), .clr_i(4'h0),
        .level_o(lvl2), .edge_o(edg2), .sticky_o(stk2), .any_o(any2)
    );

    int nVec  = 0;
    int nFail = 0;

    // Reference model: per channel, a delay line standing in for the
    // synchroniser and the list of consecutive samples that disagree with
    // the accepted level; a full list means the new level is accepted.
    bit [3:0] mLevel, mEdge, mSticky;
    bit       syncQ[NUM_CH][$];
    bit       hist[NUM_CH][$];

    function automatic void modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            syncQ[c].delete();
            hist[c].delete();
            for (int k = 0; k < SYNC; k++) syncQ[c].push_back(1'b0);
        end
        mLevel  = '0;
        mEdge   = '0;
        mSticky = '0;
    endfunction

    function automatic void modelStep(input logic [3:0] sig, input logic [7:0] mode,
                                      input logic [3:0] clr);
        bit [3:0] newEdge;
        newEdge = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bit sIn;
            sIn = syncQ[c].pop_front();
            syncQ[c].push_back(sig[c]);
            if (sIn != mLevel[c]) hist[c].push_back(sIn);
            else                  hist[c].delete();
            if (hist[c].size() == FILT) begin
                mLevel[c]  = ~mLevel[c];
                hist[c].delete();
                newEdge[c] = mLevel[c] ? mode[2*c] : mode[2*c+1];
            end
        end
        mSticky = newEdge | mEdge | (mSticky & ~clr);
        mEdge   = newEdge;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " level"},  32'(level_o),  32'(mLevel));
        checkOutput({tag, " edge"},   32'(edge_o),   32'(mEdge));
        checkOutput({tag, " sticky"}, 32'(sticky_o), 32'(mSticky));
        checkOutput({tag, " any"},    32'(any_o),    32'(|mSticky));
    endtask

    // Called just after a falling edge: drive inputs, clock once, advance
    // the model with the same inputs, and return at the next falling edge.
    task automatic applyStimulus(input logic [3:0] sig, input logic [7:0] mode,
                                 input logic [3:0] clr);
        signal_i = sig;
        mode_i   = mode;
        clr_i    = clr;
        @(posedge clk);
        modelStep(sig, mode, clr);
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] sig;
        logic [7:0] mode;
        logic [3:0] clr;
        logic [3:0] level;
        logic [3:0] edg;
        logic [3:0] sticky;
        logic       any;
    } vec_t;

    vec_t tbl[$];

    task automatic runCh2(input logic [7:0] mode, output int pulses,
                          output logic lvlHigh, output logic lvlLow);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'h4, mode, 4'h0);
            checkModel("t3 rise");
            if (edge_o[2]) pulses++;
        end
        lvlHigh = level_o[2];
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'h0, mode, 4'h0);
            checkModel("t3 fall");
            if (edge_o[2]) pulses++;
        end
        lvlLow = level_o[2];
    endtask

    initial begin
        int   pulses, n, fullCnt, partCnt;
        logic lvH, lvL;
        logic [3:0] rsig, rclr;
        logic [7:0] rmode;

        signal_i = '0; mode_i = '0; clr_i = '0; sig2 = '0;
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);

        checkOutput("reset level",  32'(level_o),  0);
        checkOutput("reset edge",   32'(edge_o),   0);
        checkOutput("reset sticky", 32'(sticky_o), 0);
        checkOutput("reset any",    32'(any_o),    0);
        rst_n = 1'b1;

        // Directed table: ch0 rise, ch1 glitch, ch0 fall with clear/set race.
        for (int i = 0; i < 5; i++) tbl.push_back('{4'h1, 8'h01, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'h1, 8'h01, 4'h0, 4'h1, 4'h1, 4'h1, 1'b1});
        tbl.push_back('{4'h1, 8'h01, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1});
        for (int i = 0; i < 3; i++) tbl.push_back('{4'h3, 8'h09, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1});
        for (int i = 0; i < 5; i++) tbl.push_back('{4'h1, 8'h09, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1});
        tbl.push_back('{4'h0, 8'h0B, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0});
        for (int i = 0; i < 4; i++) tbl.push_back('{4'h0, 8'h0B, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'h0, 8'h0B, 4'h0, 4'h0, 4'h1, 4'h1, 1'b1});
        tbl.push_back('{4'h0, 8'h0B, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1});
        tbl.push_back('{4'h0, 8'h0B, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'h0, 8'h0B, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].sig, tbl[i].mode, tbl[i].clr);
            checkOutput($sformatf("row%0d level", i),  32'(level_o),  32'(tbl[i].level));
            checkOutput($sformatf("row%0d edge", i),   32'(edge_o),   32'(tbl[i].edg));
            checkOutput($sformatf("row%0d sticky", i), 32'(sticky_o), 32'(tbl[i].sticky));
            checkOutput($sformatf("row%0d any", i),    32'(any_o),    32'(tbl[i].any));
        end

        // Ch2 in both-edge mode, then with pulses disabled.
        runCh2(8'h30, pulses, lvH, lvL);
        checkOutput("t3 both pulses", pulses, 2);
        checkOutput("t3 both level hi", 32'(lvH), 1);
        checkOutput("t3 both level lo", 32'(lvL), 0);
        runCh2(8'h00, pulses, lvH, lvL);
        checkOutput("t3 off pulses", pulses, 0);
        checkOutput("t3 off level hi", 32'(lvH), 1);
        checkOutput("t3 off level lo", 32'(lvL), 0);

        // Reset while ch3 is two samples into qualification.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'h8, 8'h40, 4'h0);
            checkModel("t5 qual");
        end
        rst_n = 1'b0;
        #1;
        checkOutput("t5 reset level",  32'(level_o),  0);
        checkOutput("t5 reset edge",   32'(edge_o),   0);
        checkOutput("t5 reset sticky", 32'(sticky_o), 0);
        checkOutput("t5 reset any",    32'(any_o),    0);
        @(negedge clk);
        @(negedge clk);
        modelReset();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'h8, 8'h40, 4'h0);
            checkModel("t5 post");
            n++;
            if (edge_o[3]) break;
        end
        checkOutput("t5 pulse latency", n, 6);

        // All channels rise together.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'h0, 8'h55, 4'hF);
            checkModel("t6 settle");
        end
        fullCnt = 0;
        partCnt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'hF, 8'h55, 4'h0);
            checkModel("t6 rise");
            if (edge_o == 4'hF) fullCnt++;
            else if (edge_o != 4'h0) partCnt++;
        end
        checkOutput("t6 full pulse cycles", fullCnt, 1);
        checkOutput("t6 partial pulse cycles", partCnt, 0);

        // Short-pipeline variant: accept one synchronised sample later.
        sig2 = 4'hF;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (edg2 != 4'h0) break;
        end
        checkOutput("fast latency edges", n - 1, 3);
        checkOutput("fast edge all", 32'(edg2), 32'hF);
        @(negedge clk);
        checkOutput("fast edge drop", 32'(edg2), 0);
        checkOutput("fast level", 32'(lvl2), 32'hF);

        // Randomized traffic: slow toggling, bursty glitches, mode/clear churn.
        rsig  = 4'h0;
        rmode = 8'hE4;
        rclr  = 4'h0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (((i / 150) % 3) == 2) begin
                    if ($urandom_range(1) == 0) rsig[b] = ~rsig[b];
                end else begin
                    if ($urandom_range(9) == 0) rsig[b] = ~rsig[b];
                end
                rclr[b] = ($urandom_range(11) == 0);
            end
            if ($urandom_range(39) == 0) rmode = 8'($urandom);
            applyStimulus(rsig, rmode, rclr);
            checkModel("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
